// File: rtl/ahbl_mtimer.sv
// AHB-Lite RISC-V machine timer: prescaled 64-bit mtime, 64-bit mtimecmp and msip,
// with zero-wait legal word accesses and a two-cycle ERROR response for illegal ones.
module ahbl_mtimer #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [7:0] PRESC_RST  = 8'd0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ahbl_hsel,
    input  logic [ADDR_WIDTH-1:0] ahbl_haddr,
    input  logic [1:0]            ahbl_htrans,
    input  logic [2:0]            ahbl_hsize,
    input  logic                  ahbl_hwrite,
    input  logic [DATA_WIDTH-1:0] ahbl_hwdata,
    input  logic                  ahbl_hreadyin,
    output logic [DATA_WIDTH-1:0] ahbl_hrdata,
    output logic                  ahbl_hreadyout,
    output logic                  ahbl_hresp,
    output logic                  irq_timer,
    output logic                  irq_soft
);

    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

    state_t state, state_nxt;

    logic        accept, legal, take;
    logic [2:0]  idx_p1;
    logic        wr_p1;
    logic        wr_en, rd_en;
    logic [31:0] rd_val;
    logic [31:0] hrdata_q;

    logic [63:0] mtime, mtimecmp;
    logic [7:0]  presc, pcnt;
    logic        en, msip;
    logic        tick;

    // Upper address bits and htrans[0] carry no meaning for this slave.
    logic unused_bits;
    assign unused_bits = ^{ahbl_haddr[ADDR_WIDTH-1:5], ahbl_htrans[0]};

    assign accept = ahbl_hsel & ahbl_htrans[1] & ahbl_hreadyin;
    assign legal  = (ahbl_hsize == 3'b010) && (ahbl_haddr[4:2] <= 3'd5) &&
                    (ahbl_haddr[1:0] == 2'b00);
    assign take   = accept & ((state == IDLE) | (state == DATA));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DATA: state_nxt = take ? (legal ? DATA : ERR1) : IDLE;
            ERR1:       state_nxt = ERR2;
            ERR2:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Address phase -> data phase
    always_ff @(posedge clk) begin
        if (take & legal) begin
            idx_p1 <= ahbl_haddr[4:2];
            wr_p1  <= ahbl_hwrite;
        end
    end

    assign wr_en = (state == DATA) & wr_p1;
    assign rd_en = (state == DATA) & ~wr_p1;

    always_comb begin
        rd_val = 32'h0;
        case (idx_p1)
            3'd0:    rd_val = mtime[31:0];
            3'd1:    rd_val = mtime[63:32];
            3'd2:    rd_val = mtimecmp[31:0];
            3'd3:    rd_val = mtimecmp[63:32];
            3'd4:    rd_val = {16'h0, presc, 7'h0, en};
            3'd5:    rd_val = {31'h0, msip};
            default: rd_val = 32'h0;
        endcase
    end

    // Read data is driven combinationally in the data phase and held afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      hrdata_q <= 32'h0;
        else if (rd_en) hrdata_q <= rd_val;
    end

    assign ahbl_hrdata    = rd_en ? rd_val : hrdata_q;
    assign ahbl_hreadyout = (state != ERR1);
    assign ahbl_hresp     = (state == ERR1) | (state == ERR2);

    assign tick = en & (pcnt == presc);

    // Bus writes are placed after the tick so the written half wins; the other half keeps its pre-tick value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mtime     <= 64'h0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc     <= PRESC_RST;
            pcnt      <= 8'h0;
            en        <= 1'b0;
            msip      <= 1'b0;
            irq_timer <= 1'b0;
        end else begin
            if (en) begin
                if (tick) begin
                    pcnt  <= 8'h0;
                    mtime <= mtime + 64'd1;
                end else begin
                    pcnt <= pcnt + 8'd1;
                end
            end
            if (wr_en) begin
                case (idx_p1)
                    3'd0: mtime <= {mtime[63:32], ahbl_hwdata[31:0]};
                    3'd1: mtime <= {ahbl_hwdata[31:0], mtime[31:0]};
                    3'd2: mtimecmp[31:0]  <= ahbl_hwdata[31:0];
                    3'd3: mtimecmp[63:32] <= ahbl_hwdata[31:0];
                    3'd4: begin
                        presc <= ahbl_hwdata[15:8];
                        en    <= ahbl_hwdata[0];
                        pcnt  <= 8'h0;
                    end
                    3'd5: msip <= ahbl_hwdata[0];
                    default: ;
                endcase
            end
            irq_timer <= (mtime >= mtimecmp) & en;
        end
    end

    assign irq_soft = msip;

endmodule

// File: tb/tb_ahbl_mtimer.sv
// Bench for ahbl_mtimer: directed scenarios plus random bus traffic checked
// cycle by cycle against a register-level model of the timer.
module tb_ahbl_mtimer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ahbl_hsel;
    logic [31:0] ahbl_haddr;
    logic [1:0]  ahbl_htrans;
    logic [2:0]  ahbl_hsize;
    logic        ahbl_hwrite;
    logic [31:0] ahbl_hwdata;
    logic        ahbl_hreadyin;
    logic [31:0] ahbl_hrdata;
    logic        ahbl_hreadyout;
    logic        ahbl_hresp;
    logic        irq_timer;
    logic        irq_soft;

    ahbl_mtimer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRESC_RST(8'd0)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .ahbl_hsel      (ahbl_hsel),
        .ahbl_haddr     (ahbl_haddr),
        .ahbl_htrans    (ahbl_htrans),
        .ahbl_hsize     (ahbl_hsize),
        .ahbl_hwrite    (ahbl_hwrite),
        .ahbl_hwdata    (ahbl_hwdata),
        .ahbl_hreadyin  (ahbl_hreadyin),
        .ahbl_hrdata    (ahbl_hrdata),
        .ahbl_hreadyout (ahbl_hreadyout),
        .ahbl_hresp     (ahbl_hresp),
        .irq_timer      (irq_timer),
        .irq_soft       (irq_soft)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Register-level reference model
    logic [63:0] m_mtime, m_cmp;
    logic [7:0]  m_presc;
    int          m_pcnt;
    logic        m_en, m_msip, m_irq;

    // Outstanding data phase: 0 none, 1 legal, 2 first error cycle, 3 second error cycle
    int          dp_kind;
    bit          dp_wr;
    int          dp_idx;
    logic [31:0] last_rd;

    task automatic model_reset();
        m_mtime = 64'h0;
        m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_presc = 8'd0;
        m_pcnt  = 0;
        m_en    = 1'b0;
        m_msip  = 1'b0;
        m_irq   = 1'b0;
        dp_kind = 0;
    endtask

    function automatic logic [31:0] m_read(input int idx);
        case (idx)
            0:       return m_mtime[31:0];
            1:       return m_mtime[63:32];
            2:       return m_cmp[31:0];
            3:       return m_cmp[63:32];
            4:       return {16'h0, m_presc, 7'h0, m_en};
            5:       return {31'h0, m_msip};
            default: return 32'h0;
        endcase
    endfunction

    // One clock: drive address phase (a_*) and the write data for the current data phase.
    task automatic step(input bit a_vld, input logic [31:0] a_addr, input logic [2:0] a_size,
                        input bit a_wr, input logic [31:0] wdata);
        logic [63:0] old_t;
        logic        irq_nxt;
        bit          lg;
        ahbl_hsel   = a_vld;
        ahbl_htrans = a_vld ? 2'b10 : 2'b00;
        ahbl_haddr  = a_addr;
        ahbl_hsize  = a_size;
        ahbl_hwrite = a_wr;
        ahbl_hwdata = wdata;
        #1;
        case (dp_kind)
            1: begin
                check("rdy_data", ahbl_hreadyout, 1'b1);
                check("resp_data", ahbl_hresp, 1'b0);
                if (!dp_wr) begin
                    check($sformatf("rd_idx%0d", dp_idx), ahbl_hrdata, m_read(dp_idx));
                    last_rd = ahbl_hrdata;
                end
            end
            2: begin
                check("rdy_err1", ahbl_hreadyout, 1'b0);
                check("resp_err1", ahbl_hresp, 1'b1);
            end
            3: begin
                check("rdy_err2", ahbl_hreadyout, 1'b1);
                check("resp_err2", ahbl_hresp, 1'b1);
            end
            default: begin
                check("rdy_idle", ahbl_hreadyout, 1'b1);
                check("resp_idle", ahbl_hresp, 1'b0);
            end
        endcase
        check("irq_timer", irq_timer, m_irq);
        check("irq_soft", irq_soft, m_msip);

        irq_nxt = (m_mtime >= m_cmp) && m_en;
        old_t   = m_mtime;
        if (m_en) begin
            if (m_pcnt == int'(m_presc)) begin
                m_pcnt  = 0;
                m_mtime = m_mtime + 64'd1;
            end else begin
                m_pcnt = m_pcnt + 1;
            end
        end
        if (dp_kind == 1 && dp_wr) begin
            case (dp_idx)
                0: m_mtime = {old_t[63:32], wdata};
                1: m_mtime = {wdata, old_t[31:0]};
                2: m_cmp[31:0]  = wdata;
                3: m_cmp[63:32] = wdata;
                4: begin m_presc = wdata[15:8]; m_en = wdata[0]; m_pcnt = 0; end
                5: m_msip = wdata[0];
                default: ;
            endcase
        end
        m_irq = irq_nxt;

        lg = (a_size == 3'b010) && (a_addr[4:2] <= 3'd5) && (a_addr[1:0] == 2'b00);
        if (dp_kind == 2)      dp_kind = 3;
        else if (dp_kind == 3) dp_kind = 0;
        else if (a_vld) begin
            dp_kind = lg ? 1 : 2;
            dp_wr   = a_wr;
            dp_idx  = int'(a_addr[4:2]);
        end else dp_kind = 0;

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'h0, 3'b010, 1'b0, 32'h0);
    endtask

    task automatic xfer(input logic [31:0] addr, input logic [2:0] size, input bit w,
                        input logic [31:0] d);
        step(1'b1, addr, size, w, 32'h0);
        step(1'b0, 32'h0, 3'b010, 1'b0, d);
        for (int k = 0; k < 3 && dp_kind != 0; k++) step(1'b0, 32'h0, 3'b010, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d);
        xfer(addr, 3'b010, 1'b1, d);
    endtask

    task automatic rd(input logic [31:0] addr);
        xfer(addr, 3'b010, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn          = 1'b0;
        ahbl_hsel     = 1'b0;
        ahbl_haddr    = 32'h0;
        ahbl_htrans   = 2'b00;
        ahbl_hsize    = 3'b010;
        ahbl_hwrite   = 1'b0;
        ahbl_hwdata   = 32'h0;
        ahbl_hreadyin = 1'b1;
        last_rd       = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_hrdata", ahbl_hrdata, 32'h0);
        check("rst_hreadyout", ahbl_hreadyout, 1'b1);
        check("rst_hresp", ahbl_hresp, 1'b0);
        check("rst_irq_timer", irq_timer, 1'b0);
        check("rst_irq_soft", irq_soft, 1'b0);
        rstn = 1'b1;
        idle(2);

        rd(32'h0C);
        check("cmp_hi_reset", last_rd, 32'hFFFF_FFFF);
        rd(32'h10);
        check("ctrl_reset", last_rd, 32'h0);

        wr(32'h10, 32'h0000_0301);
        idle(40);
        rd(32'h00);
        check("mtime_presc3", (last_rd >= 32'd9 && last_rd <= 32'd11), 1'b1);

        wr(32'h10, 32'h0);
        wr(32'h00, 32'h0);
        wr(32'h04, 32'h0);
        wr(32'h08, 32'd5);
        wr(32'h0C, 32'h0);
        wr(32'h10, 32'h0000_0001);
        idle(10);
        check("irq_rise", irq_timer, 1'b1);
        wr(32'h08, 32'hFF);
        idle(2);
        check("irq_fall", irq_timer, 1'b0);

        wr(32'h10, 32'h0);
        wr(32'h00, 32'hFFFF_FFFF);
        wr(32'h04, 32'hFFFF_FFFF);
        wr(32'h10, 32'h0000_2001);
        idle(40);
        rd(32'h04);
        check("wrap_hi", last_rd, 32'h0);
        rd(32'h00);
        check("wrap_lo", last_rd, 32'h0);

        xfer(32'h18, 3'b010, 1'b0, 32'h0);
        xfer(32'h08, 3'b000, 1'b0, 32'h0);
        xfer(32'h14, 3'b000, 1'b1, 32'h1);
        rd(32'h14);
        check("msip_after_bad_wr", last_rd, 32'h0);
        xfer(32'h0A, 3'b010, 1'b1, 32'h1234);
        rd(32'h08);
        check("cmp_after_unaligned", last_rd, 32'hFF);

        for (int c = 0; c < 600; c++) begin
            bit          v, w;
            logic [31:0] a, d;
            logic [2:0]  sz;
            v  = (dp_kind <= 1) && ($urandom_range(0, 2) != 0);
            w  = ($urandom_range(0, 1) == 1);
            a  = {27'h0, 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 3)) : 3'b010;
            d  = $urandom;
            if (dp_kind == 1 && dp_wr) begin
                if (dp_idx == 4) d = {16'h0, 8'($urandom_range(0, 3)), 7'h0, 1'($urandom_range(0, 3) != 0)};
                else if ((dp_idx == 1 || dp_idx == 3) && $urandom_range(0, 1) == 1) d = 32'h0;
            end
            step(v, a, sz, w, d);
        end
        idle(3);

        step(1'b1, 32'h14, 3'b010, 1'b1, 32'h0);
        step(1'b1, 32'h14, 3'b010, 1'b0, 32'h1);
        step(1'b0, 32'h0, 3'b010, 1'b0, 32'h0);
        check("b2b_msip_rd", last_rd, 32'h1);
        check("b2b_irq_soft", irq_soft, 1'b1);

        step(1'b1, 32'h08, 3'b010, 1'b1, 32'h0);
        ahbl_hsel   = 1'b0;
        ahbl_htrans = 2'b00;
        ahbl_hwdata = 32'h0;
        #1 rstn = 1'b0;
        #1;
        check("midrst_hrdata", ahbl_hrdata, 32'h0);
        check("midrst_hreadyout", ahbl_hreadyout, 1'b1);
        check("midrst_hresp", ahbl_hresp, 1'b0);
        check("midrst_irq_timer", irq_timer, 1'b0);
        check("midrst_irq_soft", irq_soft, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        rd(32'h08);
        check("midrst_wr_discarded", last_rd, 32'hFFFF_FFFF);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
